cnn_frame_scheduler: RTL

Front-end controller for the CNN inference core. Buffers one 28x28 u8 frame from a stallable host stream (valid/ready). Replays the frame to the core as a gap-free burst, since the core's data_valid must stay high for exactly 784 consecutive cycles. Waits for the core's decision with a timeout, then returns the result to the host through a valid/ready result port.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/cnn_frame_buf.sv | 31 +++
 rtl/cnn_frame_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN front-end scheduler.
package cnn_pkg;

  localparam int N_PIX = 784;
  localparam int IMG_W = 28;
  localparam int PIX_W = 8;
  localparam int CLS_W = 4;

  localparam logic [CLS_W-1:0] CLS_TIMEOUT = 4'hF;

  // Scheduler FSM encoding; also driven out on the debug state port.
  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_STREAM = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESULT = 3'd3,
    ST_CRST   = 3'd4
  } state_t;

endpackage

// File: rtl/cnn_frame_buf.sv
// One-frame pixel buffer: simple dual-port RAM, synchronous write port and
// registered read port. No control logic so it maps onto a block RAM.
module cnn_frame_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = N_PIX,
  parameter int DW    = PIX_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port, used while the frame is being loaded from the host.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cnn_frame_scheduler.sv
// Front-end scheduler for the CNN core: loads one frame from the host,
// replays it as a gap-free burst, waits (with timeout) for the core's
// decision and hands the result back to the host.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; a source holds its payload stable while valid && !ready,
// and ready never depends combinationally on valid.
module cnn_frame_scheduler #(
  parameter int N_PIX   = cnn_pkg::N_PIX,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DW-1:0]    core_data_in,
  output logic             core_data_valid,
  output logic             core_rst_n,
  input  logic [3:0]       core_decision,
  input  logic             core_out_valid,
  output logic [3:0]       m_decision,
  output logic             m_timeout,
  output logic [CNT_W-1:0] m_frame_id,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  import cnn_pkg::*;

  localparam int AW   = $clog2(N_PIX);
  localparam int TO_W = $clog2(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     wr_cnt;
  logic [AW-1:0]     rd_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              crst_cnt;
  logic [1:0]        hold_cnt;
  logic              cdv_q;
  logic [DW-1:0]     rd_data;
  logic              rd_en;
  logic              s_hs;
  logic              res_hs;
  logic              wr_last;
  logic              rd_last;
  logic              to_last;

  assign s_hs    = s_valid && s_ready;
  assign res_hs  = m_valid && m_ready;
  assign wr_last = (wr_cnt == AW'(N_PIX - 1));
  assign rd_last = (rd_cnt == AW'(N_PIX - 1));
  assign to_last = (to_cnt == TO_W'(TIMEOUT - 1));

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    rd_en      = 1'b0;
    core_rst_n = !rst && (hold_cnt == 2'd0);
    case (state)
      ST_LOAD: begin
        s_ready = !rst;
        if (s_hs && wr_last) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        rd_en = 1'b1;
        if (rd_last) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A decision arriving on the timeout cycle still counts as a decision.
        if (core_out_valid) state_nxt = ST_RESULT;
        else if (to_last)   state_nxt = ST_CRST;
      end
      ST_CRST: begin
        core_rst_n = 1'b0;
        // Skip RESULT when the host already took the result during the flush.
        if (crst_cnt) state_nxt = (m_valid && !m_ready) ? ST_RESULT : ST_LOAD;
      end
      ST_RESULT: begin
        if (res_hs) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  // Write/read address, timeout and core-flush counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      to_cnt   <= '0;
      crst_cnt <= 1'b0;
    end else begin
      if (s_hs) wr_cnt <= wr_last ? '0 : wr_cnt + AW'(1);
      if (s_hs && wr_last) rd_cnt <= '0;
      else if (rd_en)      rd_cnt <= rd_last ? '0 : rd_cnt + AW'(1);
      if (rd_en && rd_last)     to_cnt <= '0;
      else if (state == ST_WAIT) to_cnt <= to_cnt + TO_W'(1);
      crst_cnt <= (state == ST_CRST) ? !crst_cnt : 1'b0;
    end
  end

  // Result register: captured in WAIT, released by the host handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_decision <= '0;
      m_timeout  <= 1'b0;
      m_frame_id <= '0;
    end else if (state == ST_WAIT) begin
      if (core_out_valid) begin
        m_decision <= core_decision;
        m_timeout  <= 1'b0;
        m_valid    <= 1'b1;
      end else if (to_last) begin
        m_decision <= CLS_TIMEOUT;
        m_timeout  <= 1'b1;
        m_valid    <= 1'b1;
      end
    end else if (res_hs) begin
      m_valid    <= 1'b0;
      m_frame_id <= m_frame_id + CNT_W'(1);
    end
  end

  // Core-side strobe (aligned with the RAM read latency) and the
  // post-reset hold that keeps the core in reset for two more cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdv_q    <= 1'b0;
      hold_cnt <= 2'd2;
    end else begin
      cdv_q <= rd_en;
      if (hold_cnt != 2'd0) hold_cnt <= hold_cnt - 2'd1;
    end
  end

  cnn_frame_buf #(
    .DEPTH (N_PIX),
    .DW    (DW),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (s_hs),
    .waddr (wr_cnt),
    .wdata (s_data),
    .re    (rd_en),
    .raddr (rd_cnt),
    .rdata (rd_data)
  );

  // The RAM output register is not reset; mask it outside the burst.
  assign core_data_in    = cdv_q ? rd_data : '0;
  assign core_data_valid = cdv_q;
  assign busy            = (state != ST_LOAD) || (wr_cnt != '0);
  assign state_dbg       = state;

endmodule
